// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Time-base and set-mode sequencer for a 12-hour clock counter.
//   In normal running it divides clk down to a one-cycle 1 Hz `ena` strobe.
//   In set mode the counter is frozen, and each minute or hour advance is
//   issued as a burst of back-to-back `ena` pulses (60 or 3600). This keeps
//   the seconds field and the carry/pm chain of the counter consistent.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high
//   btn_mode  in   debounced level; rise toggles set mode
//   btn_min   in   debounced level; rise in set mode advances one minute
//   btn_hr    in   debounced level; rise in set mode advances one hour
//   ena       out  registered counter enable
//   set_mode  out  registered; high while in SET or BURST
//   busy      out  registered; high while a burst is being issued
//   blink     out  registered; 1 Hz 50 % square wave in set mode, else 0
module clock_set_ctrl #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_mode,
  input  logic btn_min,
  input  logic btn_hr,
  output logic ena,
  output logic set_mode,
  output logic busy,
  output logic blink
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(TICK_DIV / 2);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [DW-1:0] DIV_ZERO = DW'(0);

  localparam logic [11:0] BURST_MIN = 12'd60;
  localparam logic [11:0] BURST_HR  = 12'd3600;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [DW-1:0] div_r;
  logic [DW-1:0] div_nx_s;
  logic [11:0]   rem_r;
  logic [11:0]   rem_nx_s;
  logic          prev_mode_r;
  logic          prev_min_r;
  logic          prev_hr_r;
  logic          mode_rise_s;
  logic          min_rise_s;
  logic          hr_rise_s;
  logic          tick_s;
  logic          div_clr_s;
  logic          ena_nx_s;

  assign mode_rise_s = btn_mode & ~prev_mode_r;
  assign min_rise_s  = btn_min  & ~prev_min_r;
  assign hr_rise_s   = btn_hr   & ~prev_hr_r;
  assign tick_s      = (div_r == DIV_MAX);

  // Next-state, burst-length and prescaler decisions.
  always_comb begin
    state_nx_s = state_r;
    rem_nx_s   = rem_r;
    div_clr_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        // Minute/hour buttons are deliberately ignored while running.
        if (mode_rise_s) begin
          state_nx_s = ST_SET;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_SET: begin
        // Priority mode > hr > min; lower-priority rises in the same
        // cycle are consumed and lost.
        if (mode_rise_s) begin
          state_nx_s = ST_RUN;
          div_clr_s  = 1'b1;
        end else if (hr_rise_s) begin
          state_nx_s = ST_BURST;
          rem_nx_s   = BURST_HR;
        end else if (min_rise_s) begin
          state_nx_s = ST_BURST;
          rem_nx_s   = BURST_MIN;
        end else begin
          state_nx_s = ST_SET;
        end
      end
      ST_BURST: begin
        // Buttons are discarded here; only reset can abort a burst.
        // rem <= 1 (rather than == 1) keeps a corrupted count from
        // wrapping into a 4095-pulse burst.
        rem_nx_s = rem_r - 12'd1;
        if (rem_r <= 12'd1) begin
          state_nx_s = ST_SET;
        end else begin
          state_nx_s = ST_BURST;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
        rem_nx_s   = 12'd0;
      end
    endcase
  end

  // Prescaler runs in every state; restarted on leaving set mode so the
  // first running tick comes a full period later.
  always_comb begin
    if (div_clr_s || tick_s) begin
      div_nx_s = DIV_ZERO;
    end else begin
      div_nx_s = div_r + DIV_ONE;
    end
  end

  // Counter enable: the running tick (even on the edge that enters SET),
  // otherwise one pulse per cycle the next state is BURST.
  always_comb begin
    if (state_r == ST_RUN) begin
      ena_nx_s = tick_s;
    end else begin
      ena_nx_s = (state_nx_s == ST_BURST);
    end
  end

  // State, counters, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      div_r       <= DIV_ZERO;
      rem_r       <= 12'd0;
      // Load live levels so a button held through reset gives no edge.
      prev_mode_r <= btn_mode;
      prev_min_r  <= btn_min;
      prev_hr_r   <= btn_hr;
      ena         <= 1'b0;
      set_mode    <= 1'b0;
      busy        <= 1'b0;
      blink       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      div_r       <= div_nx_s;
      rem_r       <= rem_nx_s;
      prev_mode_r <= btn_mode;
      prev_min_r  <= btn_min;
      prev_hr_r   <= btn_hr;
      ena         <= ena_nx_s;
      set_mode    <= (state_nx_s != ST_RUN);
      busy        <= (state_nx_s == ST_BURST);
      // Gated by the next state so blink never outlives set_mode.
      blink       <= (state_nx_s != ST_RUN) && (div_r < DIV_HALF);
    end
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-base and set-mode sequencer for the 12-hour clock counter. Divides the board clock to a one-cycle 1 Hz `ena` strobe in normal running. In set mode it freezes the counter and advances it by issuing bursts of back-to-back `ena` pulses: 60 per minute-advance and 3600 per hour-advance. Seconds and the carry/pm chain of the counter therefore stay consistent. It sits between the debounced push-buttons and the counter's `ena` input, and also supplies a blink strobe to the display driver.

## Interface
- `TICK_DIV`, default 100000000: `clk` cycles per second tick; must be ≥ 4.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_mode` in 1: debounced level; a rising edge toggles set mode.
- `btn_min` in 1: debounced level; a rising edge in set mode advances the time by one minute.
- `btn_hr` in 1: debounced level; a rising edge in set mode advances the time by one hour.
- `ena` out 1: registered; drives the counter enable.
- `set_mode` out 1: registered; high in SET and BURST.
- `busy` out 1: registered; high while a burst is in progress.
- `blink` out 1: registered; 50 % square wave at 1 Hz in set mode, 0 otherwise.

## Operation
- Edge detect: each button has a `prev` register. A rise is `btn & ~prev`. During reset, `prev` loads the live input, so a button held through reset produces no edge.
- Prescaler `div`: counts 0..`TICK_DIV`-1 and wraps. `tick` = (`div` == `TICK_DIV`-1). `div` runs in every state. It is cleared to 0 on reset and on the SET→RUN transition.
- Burst counter `rem`: 12 bits, unsigned, loaded with 60 or 3600.
- States (reset → RUN):
  - RUN: `ena` <= `tick`. A mode rise goes to SET. `btn_min` and `btn_hr` are ignored.
  - SET: `ena` <= 0. Edges are evaluated with priority mode > hr > min.
    - Mode rise → RUN and `div` <= 0.
    - Hr rise → BURST, `rem` <= 3600.
    - Min rise → BURST, `rem` <= 60.
  - BURST: `ena` <= 1 every cycle and `rem` decrements. When `rem` == 1, the next state is SET. All button edges arriving in BURST are discarded, and `prev` still tracks the inputs.
- Ticks occurring in SET or BURST are dropped, not queued.
- `blink` <= 1 when the state is SET or BURST and `div` < `TICK_DIV`/2, else 0.
- `busy` <= (next state == BURST). `set_mode` <= (next state != RUN).

## Timing
- Reset values: `ena`=0, `set_mode`=0, `busy`=0, `blink`=0, state RUN, `div`=0, `rem`=0.
- Reset mid-burst: everything returns to the reset values on the next edge. The burst is abandoned and the remaining pulses are not issued.
- RUN tick: `ena` is high exactly one cycle, the cycle after `div` == `TICK_DIV`-1. The period is exactly `TICK_DIV` cycles. The first `ena` after reset rises at cycle `TICK_DIV`+1, counting reset release as the edge at which the first `div`=0 is registered.
- Mode rise sampled at edge k in RUN:
  - `set_mode` is high from cycle k+1.
  - If `tick` is true at edge k, that final `ena` is still issued in cycle k+1.
- Burst request sampled at edge k in SET:
  - `ena` and `busy` are high for exactly N consecutive cycles, k+1..k+N, where N is 60 or 3600.
  - Both are low at k+N+1, and the state is back in SET.
  - The next burst can start from an edge sampled at k+N+1 at the earliest.
- Mode rise sampled at edge k in SET:
  - `set_mode` is low from k+1.
  - The first RUN `ena` is high in cycle k+`TICK_DIV`+1.
- Simultaneous rises in SET: only the highest-priority one acts. The others are consumed and lost.
- No burst can be cut short by buttons. Only `reset` aborts it.

## Test plan
- `TICK_DIV`=10, reset 3 cycles then release → `ena` pulses once every 10 cycles, width 1, first at cycle 11; all outputs 0 during reset.
- RUN, mode rise, then min rise → exactly 60 consecutive `ena` cycles with `busy`=1; with the counter attached, 12:00:00 becomes 12:01:00 and `ss` is unchanged.
- SET, hr rise at 11:59:30 am → 3600 `ena` cycles; the counter reads 12:59:30 with `pm`=1; `set_mode` stays 1 throughout.
- SET, `btn_mode`, `btn_hr` and `btn_min` rise in the same cycle → immediate return to RUN, no burst, first `ena` 10 cycles later.
- During a 3600 burst, pulse `btn_min` and `btn_mode` → ignored, total `ena` count exactly 3600. Assert `reset` at pulse 1000 → `ena`=0 next cycle, state RUN, total 1000 pulses.
- Hold `btn_mode` high through reset, release reset → no SET entry; `blink` toggles every 5 cycles only while `set_mode`=1.
